// File: rtl/frecuencimetro_if.sv
// Pin bundle of the frequency meter: measured square wave in, multiplexed
// 7-segment bus, overflow LED and result-ready pulse out.
interface frecuencimetro_if;
    logic        ENTRADA;
    logic [15:0] DISPLAY;
    logic        LED;
    logic        LISTO;

    modport master (output ENTRADA, input DISPLAY, input LED, input LISTO);
    modport slave  (input ENTRADA, output DISPLAY, output LED, output LISTO);
endinterface

// File: rtl/frecuencimetro.sv
// Frequency meter: counts ENTRADA rising edges over a fixed gate window and
// shows the count (0..9999 Hz) on a 4-digit multiplexed 7-segment display.
module frecuencimetro #(
    parameter int unsigned F_CLK       = 50_000_000,
    parameter int unsigned GATE_CYCLES = F_CLK,
    parameter int unsigned SCAN_DIV    = 41_667
) (
    input logic             CLK,
    input logic             RST,
    frecuencimetro_if.slave bus
);

    localparam int unsigned       SCAN_W    = $clog2(SCAN_DIV + 1);
    localparam logic [25:0]       GATE_LAST = 26'(GATE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [13:0]       CNT_MAX   = 14'd9999;

    typedef enum logic {ESPERA, CONVIERTE} estado_t;

    logic              sync1, sync2, sync3;
    logic              pulso;
    logic [25:0]       gate_cnt;
    logic              cierre;
    logic [13:0]       cnt, cnt_next;
    logic              ovf, sat;
    logic [13:0]       medida;
    logic              ovf_lat;

    estado_t           estado;
    logic [15:0]       bcd, bcd_adj, bcd_next;
    logic [3:0]        iter;
    logic [3:0]        mill, cent, dece, unid;
    logic              led_q, listo_q;

    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        idx;
    logic [3:0]        digito;
    logic [7:0]        seg, an;
    logic [15:0]       display_q;

    assign pulso    = sync2 & ~sync3;
    assign cierre   = (gate_cnt == GATE_LAST);
    assign sat      = pulso & (cnt == CNT_MAX);
    assign cnt_next = (pulso && cnt != CNT_MAX) ? cnt + 14'd1 : cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            gate_cnt <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            medida   <= '0;
            ovf_lat  <= 1'b0;
        end else begin
            sync1 <= bus.ENTRADA;
            sync2 <= sync1;
            sync3 <= sync2;
            if (cierre) begin
                gate_cnt <= '0;
                medida   <= cnt_next;
                ovf_lat  <= ovf | sat;
                cnt      <= '0;
                ovf      <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + 26'd1;
                cnt      <= cnt_next;
                ovf      <= ovf | sat;
            end
        end
    end

    // MEDIDA stays stable for the whole conversion (gate >= 16 clocks), so the
    // double-dabble feeds its bits straight from it, MSB first, by iteration.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[14:0], medida[4'd13 - iter]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            estado  <= ESPERA;
            bcd     <= '0;
            iter    <= '0;
            mill    <= '0;
            cent    <= '0;
            dece    <= '0;
            unid    <= '0;
            led_q   <= 1'b0;
            listo_q <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (cierre) begin
                        estado <= CONVIERTE;
                        bcd    <= '0;
                        iter   <= '0;
                    end
                end
                CONVIERTE: begin
                    bcd  <= bcd_next;
                    iter <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        mill    <= bcd_next[15:12];
                        cent    <= bcd_next[11:8];
                        dece    <= bcd_next[7:4];
                        unid    <= bcd_next[3:0];
                        led_q   <= ovf_lat;
                        listo_q <= 1'b1;
                        estado  <= ESPERA;
                    end
                end
            endcase
        end
    end

    always_comb begin
        digito = mill;
        an     = 8'h7F;
        case (idx)
            2'd0: begin digito = mill; an = 8'h7F; end
            2'd1: begin digito = cent; an = 8'hBF; end
            2'd2: begin digito = dece; an = 8'hDF; end
            2'd3: begin digito = unid; an = 8'hEF; end
        endcase
        case (digito)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt  <= '0;
            idx       <= '0;
            display_q <= 16'h037F;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            display_q <= {seg, an};
        end
    end

    assign bus.DISPLAY = display_q;
    assign bus.LED     = led_q;
    assign bus.LISTO   = listo_q;

endmodule

// File: tb/tb_frecuencimetro.sv
// Directed bench for frecuencimetro: a 1000-clock gate instance for latency,
// scan, boundary and reset cases, and a 20000-clock instance for overflow.
module tb_frecuencimetro;

    logic CLK   = 1'b0;
    logic RST_S = 1'b1;
    logic RST_B = 1'b1;

    always #5 CLK = ~CLK;

    frecuencimetro_if bus_s ();
    frecuencimetro_if bus_b ();

    frecuencimetro #(.GATE_CYCLES(1000), .SCAN_DIV(4)) dut (
        .CLK (CLK),
        .RST (RST_S),
        .bus (bus_s)
    );

    frecuencimetro #(.GATE_CYCLES(20000), .SCAN_DIV(4)) dut_big (
        .CLK (CLK),
        .RST (RST_B),
        .bus (bus_b)
    );

    int          checks = 0;
    int          errors = 0;
    int          n[2];
    int          g_start[2], g_per[2], g_left[2], g_ph[2];
    logic        ent[2];
    logic [15:0] disp[2];
    logic        led[2], listo[2];

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 8'h03;
            4'd1: return 8'h9F;
            4'd2: return 8'h25;
            4'd3: return 8'h0D;
            4'd4: return 8'h99;
            4'd5: return 8'h49;
            4'd6: return 8'h41;
            4'd7: return 8'h1F;
            4'd8: return 8'h01;
            4'd9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] an_of(input int unsigned i);
        case (i)
            0: return 8'h7F;
            1: return 8'hBF;
            2: return 8'hDF;
            default: return 8'hEF;
        endcase
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, drive both square-wave generators
    // for the coming rising edge n[d], then sample both DUTs.
    task automatic tick();
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            n[d]++;
            if (g_left[d] > 0 && n[d] >= g_start[d]) begin
                if (g_ph[d] == 0) begin
                    ent[d]    = 1'b1;
                    g_left[d] = g_left[d] - 1;
                end else if (g_ph[d] == g_per[d] / 2) begin
                    ent[d] = 1'b0;
                end
                g_ph[d] = (g_ph[d] + 1 == g_per[d]) ? 0 : g_ph[d] + 1;
            end else begin
                ent[d]  = 1'b0;
                g_ph[d] = 0;
            end
        end
        bus_s.ENTRADA = ent[0];
        bus_b.ENTRADA = ent[1];
        disp[0]  = bus_s.DISPLAY;  disp[1]  = bus_b.DISPLAY;
        led[0]   = bus_s.LED;      led[1]   = bus_b.LED;
        listo[0] = bus_s.LISTO;    listo[1] = bus_b.LISTO;
        for (int d = 0; d < 2; d++)
            chk($countones(~disp[d][7:0]), 1, d == 0 ? "onehot_s" : "onehot_b");
    endtask

    task automatic gen(input int d, input int start, input int per, input int cnt);
        g_start[d] = start;
        g_per[d]   = per;
        g_left[d]  = cnt;
        g_ph[d]    = 0;
    endtask

    task automatic wait_listo(input int d, input int exp_n, input string tag);
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!listo[d] && guard < 25000);
        chk(listo[d], 1, {tag, "_seen"});
        chk(n[d], exp_n, {tag, "_cycle"});
        tick();
        chk(listo[d], 0, {tag, "_width"});
    endtask

    task automatic check_scan(input int d, input logic [15:0] digits, input logic led_exp,
                              input string tag);
        int unsigned i;
        logic [3:0]  nib;
        chk(led[d], led_exp, {tag, "_led"});
        for (int k = 0; k < 16; k++) begin
            tick();
            i   = ((n[d] - 1) / 4) % 4;
            nib = digits[15 - 4*i -: 4];
            chk(disp[d], {seg_of(nib), an_of(i)}, {tag, "_disp"});
        end
    endtask

    initial begin
        bus_s.ENTRADA = 1'b0;
        bus_b.ENTRADA = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n[d] = 0;
            ent[d] = 1'b0;
            gen(d, 32'h7FFF_FFFF, 2, 0);
        end

        // 1: reset values, then idle first window
        repeat (4) tick();
        chk(disp[0], 16'h037F, "rst_disp");
        chk(led[0], 0, "rst_led");
        chk(listo[0], 0, "rst_listo");
        chk(disp[1], 16'h037F, "rst_disp_b");
        tick();
        RST_S = 1'b0;
        RST_B = 1'b0;
        n[0] = 0;
        n[1] = 0;
        gen(0, 1000, 10, 100);        // window 2: 100 edges
        gen(1, 19998, 2, 10000);      // big window 2: 10000 edges
        wait_listo(0, 1014, "w1");
        check_scan(0, 16'h0000, 1'b0, "w1");

        // 2: 100 edges
        wait_listo(0, 2014, "w2");
        check_scan(0, 16'h0100, 1'b0, "w2");

        // 4: edge landing on gate count 999 belongs to the closing window
        gen(0, 2997, 2, 1);
        wait_listo(0, 3014, "w3");
        check_scan(0, 16'h0001, 1'b0, "w3");
        gen(0, 3998, 2, 1);           // lands on gate count 0 of window 5
        wait_listo(0, 4014, "w4");
        check_scan(0, 16'h0000, 1'b0, "w4");
        wait_listo(0, 5014, "w5");
        check_scan(0, 16'h0001, 1'b0, "w5");

        // 5: reset at gate count 500 with 50 edges pending
        gen(0, 5100, 6, 50);
        while (n[0] < 5500) tick();
        RST_S = 1'b1;
        repeat (3) tick();
        chk(disp[0], 16'h037F, "rst2_disp");
        chk(led[0], 0, "rst2_led");
        chk(listo[0], 0, "rst2_listo");
        tick();
        RST_S = 1'b0;
        n[0] = 0;
        gen(0, 10, 4, 20);
        wait_listo(0, 1014, "w6");
        check_scan(0, 16'h0020, 1'b0, "w6");

        // 3: overflow saturates at 9999, next in-range window clears LED
        wait_listo(1, 20014, "b1");
        chk(led[1], 0, "b1_led");
        wait_listo(1, 40014, "b2");
        check_scan(1, 16'h9999, 1'b1, "b2");
        gen(1, 40100, 2, 37);
        wait_listo(1, 60014, "b3");
        check_scan(1, 16'h0037, 1'b0, "b3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
